// File: rtl/tile_board_renderer_if.sv
// Board-renderer bus: repaint request, tile selection, board read port and
// VGA adapter pixel write, seen from the game side (master) and renderer (slave).
interface tile_board_renderer_if;
  logic       redraw_req;
  logic [3:0] sel_idx;
  logic       sel_valid;
  logic [3:0] rd_idx;
  logic [4:0] rd_data;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  modport master (
    output redraw_req, sel_idx, sel_valid, rd_data,
    input  rd_idx, vga_x, vga_y, vga_colour, vga_plot, busy, done
  );

  modport slave (
    input  redraw_req, sel_idx, sel_valid, rd_data,
    output rd_idx, vga_x, vga_y, vga_colour, vga_plot, busy, done
  );
endinterface

// File: rtl/tile_board_renderer.sv
// Paints the 2x5 tile board into the VGA frame buffer, one pixel per clock,
// fetching each tile's state through a 1-cycle-latency read port.
module tile_board_renderer #(
  parameter int unsigned NUM_TILES = 10,
  parameter int unsigned TILE_W    = 24,
  parameter int unsigned TILE_H    = 24,
  parameter int unsigned GAP       = 8,
  parameter int unsigned ORIGIN_X  = 8,
  parameter int unsigned ORIGIN_Y  = 28
) (
  input  logic                 CLOCK_50,
  input  logic                 userquit,
  tile_board_renderer_if.slave brd
);

  localparam int unsigned NumCols = 5;
  localparam int unsigned NumRows = NUM_TILES / NumCols;
  localparam int unsigned PxW     = $clog2(TILE_W);
  localparam int unsigned PyW     = $clog2(TILE_H);
  localparam int unsigned ColW    = $clog2(NumCols);
  localparam int unsigned RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StDraw, StDone} state_e;

  state_e          r_state, w_state_d;
  logic [3:0]      r_tile, w_tile_d;
  logic [ColW-1:0] r_col, w_col_d;
  logic [RowW-1:0] r_row, w_row_d;
  logic [PxW-1:0]  r_px, w_px_d;
  logic [PyW-1:0]  r_py, w_py_d;
  logic [4:0]      r_tdata, w_tdata_d;
  logic            r_pending, w_pending_d;

  logic [3:0]      r_rd_idx, w_rd_idx_d;
  logic [7:0]      r_x, w_x_d;
  logic [6:0]      r_y, w_y_d;
  logic [2:0]      r_colour, w_colour_d;
  logic            r_plot, w_plot_d;
  logic            r_busy, w_busy_d;
  logic            r_done, w_done_d;

  logic [2:0]      w_interior;
  logic            w_border;
  logic            w_sel_hit;

  always_ff @(posedge CLOCK_50) begin
    if (userquit) begin
      r_state    <= StIdle;
      r_tile     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_px       <= '0;
      r_py       <= '0;
      r_tdata    <= '0;
      r_pending  <= 1'b0;
      r_rd_idx   <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_colour   <= '0;
      r_plot     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_tile     <= w_tile_d;
      r_col      <= w_col_d;
      r_row      <= w_row_d;
      r_px       <= w_px_d;
      r_py       <= w_py_d;
      r_tdata    <= w_tdata_d;
      r_pending  <= w_pending_d;
      r_rd_idx   <= w_rd_idx_d;
      r_x        <= w_x_d;
      r_y        <= w_y_d;
      r_colour   <= w_colour_d;
      r_plot     <= w_plot_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_tile_d    = r_tile;
    w_col_d     = r_col;
    w_row_d     = r_row;
    w_px_d      = r_px;
    w_py_d      = r_py;
    w_tdata_d   = r_tdata;
    w_pending_d = r_pending;
    unique case (r_state)
      StIdle: begin
        w_pending_d = 1'b0;
        if (brd.redraw_req) begin
          w_state_d = StFetch;
          w_tile_d  = '0;
          w_col_d   = '0;
          w_row_d   = '0;
        end
      end
      StFetch: begin
        w_state_d = StWait;
        if (brd.redraw_req) w_pending_d = 1'b1;
      end
      StWait: begin
        w_state_d = StDraw;
        w_px_d    = '0;
        w_py_d    = '0;
        w_tdata_d = brd.rd_data;
        if (brd.redraw_req) w_pending_d = 1'b1;
      end
      StDraw: begin
        if (brd.redraw_req) w_pending_d = 1'b1;
        if (r_px == PxW'(TILE_W - 1)) begin
          w_px_d = '0;
          if (r_py == PyW'(TILE_H - 1)) begin
            w_py_d = '0;
            if (r_tile == 4'(NUM_TILES - 1)) begin
              w_state_d = StDone;
            end else begin
              w_state_d = StFetch;
              w_tile_d  = r_tile + 4'd1;
              if (r_col == ColW'(NumCols - 1)) begin
                w_col_d = '0;
                w_row_d = r_row + RowW'(1);
              end else begin
                w_col_d = r_col + ColW'(1);
              end
            end
          end else begin
            w_py_d = r_py + PyW'(1);
          end
        end else begin
          w_px_d = r_px + PxW'(1);
        end
      end
      StDone: begin
        // A request landing in the DONE cycle itself also triggers the restart.
        w_pending_d = 1'b0;
        if (r_pending || brd.redraw_req) begin
          w_state_d = StFetch;
          w_tile_d  = '0;
          w_col_d   = '0;
          w_row_d   = '0;
        end else begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_interior = 3'b001;
    unique case (w_tdata_d[4:3])
      2'b01:   w_interior = (w_tdata_d[2:0] == 3'b000) ? 3'b111 : w_tdata_d[2:0];
      2'b10:   w_interior = 3'b000;
      default: w_interior = 3'b001;
    endcase
  end

  assign w_border  = (w_px_d == '0) || (w_px_d == PxW'(TILE_W - 1)) ||
                     (w_py_d == '0) || (w_py_d == PyW'(TILE_H - 1));
  // Out-of-range selections can never equal a real tile, but guard explicitly.
  assign w_sel_hit = brd.sel_valid && (brd.sel_idx == w_tile_d) &&
                     (32'(brd.sel_idx) < NUM_TILES);

  // Outputs are computed from the next state so they are registered yet aligned.
  always_comb begin
    w_rd_idx_d = r_rd_idx;
    w_x_d      = r_x;
    w_y_d      = r_y;
    w_colour_d = r_colour;
    w_plot_d   = (w_state_d == StDraw);
    w_busy_d   = (w_state_d != StIdle);
    w_done_d   = (w_state_d == StDone);
    if (w_state_d == StFetch) w_rd_idx_d = w_tile_d;
    if (w_state_d == StDraw) begin
      w_x_d      = 8'(ORIGIN_X + 32'(w_col_d) * (TILE_W + GAP) + 32'(w_px_d));
      w_y_d      = 7'(ORIGIN_Y + 32'(w_row_d) * (TILE_H + GAP) + 32'(w_py_d));
      w_colour_d = (w_border && w_sel_hit) ? 3'b110 : w_interior;
    end
  end

  assign brd.rd_idx     = r_rd_idx;
  assign brd.vga_x      = r_x;
  assign brd.vga_y      = r_y;
  assign brd.vga_colour = r_colour;
  assign brd.vga_plot   = r_plot;
  assign brd.busy       = r_busy;
  assign brd.done       = r_done;

endmodule

// File: tb/tb_tile_board_renderer.sv
// Scoreboard bench for tile_board_renderer: expected pixels are queued per
// repaint and a negedge monitor pops and compares every plotted pixel.
module tb_tile_board_renderer;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n110     = 0;
  int   pix_fail = 0;

  logic [17:0] exp_q[$];
  logic [4:0]  board [16];

  logic [3:0] last_idx  = '0;
  logic       last_busy = 1'b0;
  logic       pres_last = 1'b0;

  tile_board_renderer_if brd ();

  tile_board_renderer dut (
    .CLOCK_50 (clk),
    .userquit (rst),
    .brd      (brd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read port model: valid data only the cycle after an index is presented.
  always @(negedge clk) begin
    logic pres_cur;
    pres_cur = (brd.rd_idx != last_idx) || (brd.busy && !last_busy);
    if (pres_last) brd.rd_data = board[last_idx];
    else           brd.rd_data = board[brd.rd_idx] ^ 5'($urandom_range(1, 31));
    last_idx  = brd.rd_idx;
    last_busy = brd.busy;
    pres_last = pres_cur;
  end

  always @(negedge clk) begin
    if (brd.vga_plot === 1'b1) begin
      logic [17:0] e;
      logic [17:0] a;
      checks++;
      a = {brd.vga_x, brd.vga_y, brd.vga_colour};
      if (brd.vga_colour == 3'b110) n110++;
      if (exp_q.size() == 0) begin
        failures++;
        if (pix_fail < 20)
          $display("FAIL pixel_unexpected: got x=%0d y=%0d c=%0d required no plot",
                   a[17:10], a[9:3], a[2:0]);
        pix_fail++;
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          failures++;
          if (pix_fail < 20)
            $display("FAIL pixel: got x=%0d y=%0d c=%0d required x=%0d y=%0d c=%0d",
                     a[17:10], a[9:3], a[2:0], e[17:10], e[9:3], e[2:0]);
          pix_fail++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic set_all(input logic [4:0] v);
    for (int i = 0; i < 16; i++) board[i] = v;
  endtask

  task automatic push_frame();
    for (int t = 0; t < 10; t++) begin
      for (int py = 0; py < 24; py++) begin
        for (int px = 0; px < 24; px++) begin
          int         x;
          int         y;
          logic [2:0] inner;
          logic [2:0] c;
          logic       edge_px;
          x = 8 + (t % 5) * 32 + px;
          y = 28 + (t / 5) * 32 + py;
          case (board[t][4:3])
            2'b01:   inner = (board[t][2:0] == 3'd0) ? 3'b111 : board[t][2:0];
            2'b10:   inner = 3'b000;
            default: inner = 3'b001;
          endcase
          edge_px = (px == 0) || (px == 23) || (py == 0) || (py == 23);
          c = (edge_px && brd.sel_valid && (int'(brd.sel_idx) == t)) ? 3'b110 : inner;
          exp_q.push_back({8'(x), 7'(y), c});
        end
      end
    end
  endtask

  task automatic run_frame(input string name);
    int t0;
    int k;
    push_frame();
    tick();
    brd.redraw_req = 1'b1;
    t0 = cyc;
    tick();
    brd.redraw_req = 1'b0;
    check({name, "_busy_rise"}, int'(brd.busy), 1);
    k = 0;
    while (brd.done !== 1'b1 && k < 7000) begin
      tick();
      k++;
    end
    check({name, "_done_latency"}, cyc - t0, 5781);
    tick();
    check({name, "_done_width"}, int'(brd.done), 0);
    check({name, "_busy_fall"}, int'(brd.busy), 0);
    check({name, "_pixels_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int t0;
    int k;
    int dn;
    int gap;
    rst            = 1'b1;
    brd.redraw_req = 1'b0;
    brd.sel_idx    = 4'd0;
    brd.sel_valid  = 1'b0;
    brd.rd_data    = 5'd0;
    set_all(5'b00_000);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_plot", int'(brd.vga_plot), 0);
    check("rst_busy", int'(brd.busy), 0);
    check("rst_done", int'(brd.done), 0);
    check("rst_x", int'(brd.vga_x), 0);
    check("rst_y", int'(brd.vga_y), 0);
    check("rst_colour", int'(brd.vga_colour), 0);
    check("rst_rd_idx", int'(brd.rd_idx), 0);

    run_frame("hidden");

    set_all(5'b01_101);
    board[3] = 5'b01_000;
    board[7] = 5'b10_011;
    run_frame("mixed");

    set_all(5'b00_010);
    brd.sel_valid = 1'b1;
    brd.sel_idx   = 4'd4;
    base = n110;
    run_frame("sel4");
    check("sel4_border_count", n110 - base, 92);

    brd.sel_idx = 4'd12;
    board[9] = 5'b11_110;
    base = n110;
    run_frame("sel12");
    check("sel12_border_count", n110 - base, 0);
    brd.sel_valid = 1'b0;

    // Back-to-back repaint: three extra requests collapse into one restart.
    push_frame();
    push_frame();
    tick();
    brd.redraw_req = 1'b1;
    t0 = cyc;
    tick();
    brd.redraw_req = 1'b0;
    dn  = 0;
    gap = 0;
    k   = 0;
    while (dn < 2 && k < 13000) begin
      tick();
      k++;
      brd.redraw_req = (k == 100) || (k == 1000) || (k == 3000);
      if (brd.done === 1'b1) dn++;
      if (dn == 1 && brd.busy !== 1'b1) gap++;
    end
    brd.redraw_req = 1'b0;
    check("pend_done_count", dn, 2);
    check("pend_busy_gap", gap, 0);
    check("pend_second_done", cyc - t0, 11562);
    tick();
    check("pend_no_third", int'(brd.busy), 0);
    check("pend_pixels_left", exp_q.size(), 0);

    // Abort mid-repaint, then a fresh request must start over from tile 0.
    push_frame();
    tick();
    brd.redraw_req = 1'b1;
    t0 = cyc;
    tick();
    brd.redraw_req = 1'b0;
    k = 0;
    while (cyc < t0 + 2000 && k < 3000) begin
      tick();
      k++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_plot", int'(brd.vga_plot), 0);
    check("abort_busy", int'(brd.busy), 0);
    check("abort_done", int'(brd.done), 0);
    exp_q.delete();
    dn = 0;
    for (int i = 0; i < 6000; i++) begin
      tick();
      if (brd.done === 1'b1) dn++;
    end
    check("abort_no_done", dn, 0);
    run_frame("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_board_renderer.md
Name: tile_board_renderer

Overview:
- Reads the tile board state that the in-game FSM writes, and paints the board onto the 160x120, 3-bit-colour VGA adapter frame buffer, one pixel per clock.
- Sits between the game FSMs and the VGA adapter, replacing the HEX/LEDR display path for board state.
- Reads tiles through a 1-cycle-latency read port, so the board owner keeps its storage private.

Parameters:
- NUM_TILES, 10, tiles on the board (2 rows x 5 columns, index = row*5 + col).
- TILE_W, 24, tile width in pixels.
- TILE_H, 24, tile height in pixels.
- GAP, 8, pixels between adjacent tiles, horizontal and vertical.
- ORIGIN_X, 8, x of tile 0 top-left corner.
- ORIGIN_Y, 28, y of tile 0 top-left corner.

Ports:
- CLOCK_50  in  1  system clock; all logic is on the rising edge.
- userquit  in  1  reset; synchronous, active-high.
- redraw_req  in  1  1-cycle pulse requesting a full board repaint.
- sel_idx  in  4  index of the currently selected tile.
- sel_valid  in  1  sel_idx is meaningful.
- rd_idx  out  4  tile index presented to the board read port.
- rd_data  in  5  [4:3] status (00 hidden, 01 revealed, 10 matched, 11 reserved), [2:0] symbol. Valid the cycle after rd_idx is presented.
- vga_x  out  8  pixel x.
- vga_y  out  7  pixel y.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  write-enable to the VGA adapter.
- busy  out  1  repaint in progress.
- done  out  1  1-cycle pulse when a repaint completes.

Behaviour:
- Reset values: all outputs 0, state IDLE, tile counter 0, pending flag cleared.
- Reset mid-repaint: aborts on the next edge; vga_plot is 0 the cycle after reset is sampled, and no further plots are issued.
- States: IDLE, FETCH, WAIT, DRAW, DONE. All outputs are registered.
- IDLE: on redraw_req go to FETCH with tile=0. busy=0.
- FETCH: rd_idx=tile. Next state is WAIT.
- WAIT: capture rd_data into the tile register at the end of the cycle. Reset px=py=0. Next state is DRAW.
- DRAW: one pixel per cycle, vga_plot=1.
  - vga_x = ORIGIN_X + col*(TILE_W+GAP) + px.
  - vga_y = ORIGIN_Y + row*(TILE_H+GAP) + py.
  - Scan order: px increments fastest; py increments when px wraps 23->0.
  - After pixel (23,23): go to DONE if tile == NUM_TILES-1, else FETCH with tile+1.
- DONE: done=1 for exactly 1 cycle. Next state is FETCH (tile=0, pending cleared) if pending is set, else IDLE.
- busy=1 in FETCH, WAIT, DRAW and DONE.
- Timing:
  - Each tile takes 578 cycles (1 FETCH + 1 WAIT + 576 DRAW).
  - A full repaint takes 5780 cycles plus 1 DONE cycle.
  - busy rises the cycle after redraw_req.
- Colour of interior pixels:
  - hidden or reserved: 3'b001.
  - revealed: the symbol value, except symbol 0 draws 3'b111.
  - matched: 3'b000.
- Border pixels are those with px in {0,23} or py in {0,23}.
  - If sel_valid=1 and sel_idx equals the current tile, border colour is 3'b110.
  - Otherwise border colour is the interior colour.
  - sel_idx and sel_valid are sampled each DRAW cycle, so a selection change mid-tile affects the remaining pixels only.
- Requests during a repaint:
  - redraw_req while busy (including the DONE cycle) sets pending. Multiple requests collapse into one.
  - Pending causes exactly one immediate restart after DONE.
- Width rules:
  - Coordinate arithmetic is done at 9 bits, then truncated.
  - Default parameters keep x at or below 159 and y at or below 83; no clipping is required.
  - sel_idx values of NUM_TILES or more never match any tile.
- rd_idx holds its last value outside FETCH.

Test Plan:
- Reset, then redraw_req with all tiles hidden and sel_valid=0 -> 5760 plots, all colour 3'b001. First plot is (8,28) and last is (159,83). done pulses once, 5781 cycles after the request cycle.
- Tile 3 revealed with symbol 0, tile 7 matched, others revealed with symbol 5 -> tile 3 (x 104..127, y 28..51) draws 3'b111. Tile 7 (x 72..95, y 60..83) draws 3'b000. All other tiles draw 3'b101.
- sel_valid=1, sel_idx=4, all hidden -> tile 4 has 92 border pixels at 3'b110 and 484 interior pixels at 3'b001. Other tiles have no 3'b110 pixels.
- Three redraw_req pulses during one repaint -> exactly two done pulses total, and busy stays high across the boundary with no IDLE cycle between them.
- userquit asserted at cycle 2000 of a repaint -> next cycle vga_plot=0, busy=0, done never pulses. A fresh redraw_req then restarts at tile 0.
- Read-port latency check: the bench model returns data exactly 1 cycle after rd_idx changes and corrupts rd_data on all other cycles -> rendered colours are still correct.
